fcb_uart_rx: RTL and testbench

UART receive engine for the FCB serial configuration port, sitting directly downstream of `baud_generator`. It detects the start bit on the synchronized serial line and pulses `baud_generator`'s `smc_clear_br_cnt` to phase-align the baud counter. It samples every bit on the mid-bit strobe `Baud_rate_re`, checks optional parity and the stop bit, and presents each received word through a one-entry valid/ready holding register.

---
 rtl/fcb_uart_pkg.sv | 36 +++
 rtl/fcb_sync_ff.sv | 39 +++
 rtl/fcb_uart_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_fcb_uart_rx.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcb_uart_pkg.sv
// Purpose: shared types and constants for the FCB UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fcb_uart_pkg;

    // Receive FSM states. BREAK is the state entered after a bad stop bit.
    // In BREAK the FSM waits for the line to return high, so a line held
    // low cannot start a new frame.
    typedef enum logic [2:0] {
        UART_RX_IDLE   = 3'd0,
        UART_RX_START  = 3'd1,
        UART_RX_DATA   = 3'd2,
        UART_RX_PARITY = 3'd3,
        UART_RX_STOP   = 3'd4,
        UART_RX_BREAK  = 3'd5
    } uart_rx_state_t;

    // Level of an idle serial line. The synchronizer resets to this value.
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Widest frame supported. The data-bit counter is sized from this value.
    localparam int UART_MAX_DATA_BITS = 8;

    // The counter must be able to hold UART_MAX_DATA_BITS.
    localparam int UART_BIT_CNT_W = $clog2(UART_MAX_DATA_BITS + 1);

    // Check a received parity bit against the running XOR of the data bits.
    // Even parity expects the XOR of the data and the parity bit to be 0.
    // Odd parity expects it to be 1.
    function automatic logic uart_parity_bad(input logic data_xor,
                                             input logic parity_bit,
                                             input logic parity_odd);
        return (data_xor ^ parity_bit) != parity_odd;
    endfunction

endpackage : fcb_uart_pkg

// File: rtl/fcb_sync_ff.sv
// Purpose: N-stage flop synchronizer for a single asynchronous bit; resets to line-idle.
// Latency: N clk cycles from d_i to q_o.
// Backpressure: none; free-running.
//
// Ports:
//   clk_i    in   clock
//   rst_n_i  in   asynchronous active-low reset (all stages go to UART_IDLE_LEVEL)
//   d_i      in   asynchronous input
//   q_o      out  synchronized output
module fcb_sync_ff
    import fcb_uart_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] stage_q;
    logic [N-1:0] stage_d;

    // Stage 0 captures the raw input. Each later stage takes the stage before it.
    always_comb begin
        stage_d = {stage_q[N-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stage_q <= {N{UART_IDLE_LEVEL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[N-1];

endmodule : fcb_sync_ff

// File: rtl/fcb_uart_rx.sv
// Purpose: UART receive engine: start detect, baud re-align, bit sampling, parity/stop check, 1-entry holding reg.
// Latency: Clear_Br_Cnt_o SYNC_STAGES+1 cycles after the Rx_i fall; word/error pulses 1 cycle after the stop-bit strobe.
// Backpressure: valid/ready holding register; a word that completes while the register is full and not being read is dropped with Overrun_Err_o.
//
// Ports:
//   Bus_Clk_i       in   bus clock (shared with baud_generator)
//   RSTn_i          in   asynchronous active-low reset
//   Rx_i            in   asynchronous serial line, idles high
//   Baud_rate_re_i  in   one-cycle mid-bit strobe from baud_generator
//   Clear_Br_Cnt_o  out  one-cycle pulse to phase-align baud_generator
//   Parity_En_i     in   frame carries a parity bit
//   Parity_Odd_i    in   1 = odd parity, 0 = even parity
//   Rx_Data_o       out  received word, right-aligned
//   Rx_Valid_o      out  holding register full
//   Rx_Ready_i      in   consumer accepts the word while Rx_Valid_o is high
//   Parity_Err_o    out  one-cycle pulse; the delivered word had bad parity
//   Frame_Err_o     out  one-cycle pulse; stop bit sampled low
//   Overrun_Err_o   out  one-cycle pulse; completed word discarded
//   Busy_o          out  FSM not in IDLE
module fcb_uart_rx
    import fcb_uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Bus_Clk_i,
    input  logic                 RSTn_i,
    input  logic                 Rx_i,
    input  logic                 Baud_rate_re_i,
    output logic                 Clear_Br_Cnt_o,
    input  logic                 Parity_En_i,
    input  logic                 Parity_Odd_i,
    output logic [DATA_BITS-1:0] Rx_Data_o,
    output logic                 Rx_Valid_o,
    input  logic                 Rx_Ready_i,
    output logic                 Parity_Err_o,
    output logic                 Frame_Err_o,
    output logic                 Overrun_Err_o,
    output logic                 Busy_o
);

    localparam logic [UART_BIT_CNT_W-1:0] BIT_LAST = UART_BIT_CNT_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Line synchronizer and previous-sample flop for falling-edge detect
    // ------------------------------------------------------------------
    logic rx_sync;

    fcb_sync_ff #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk_i   (Bus_Clk_i),
        .rst_n_i (RSTn_i),
        .d_i     (Rx_i),
        .q_o     (rx_sync)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    uart_rx_state_t              state_q,    state_d;
    logic                        rx_prev_q,  rx_prev_d;
    logic [UART_BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0]        shreg_q,    shreg_d;
    logic                        par_acc_q,  par_acc_d;
    logic                        par_bit_q,  par_bit_d;
    logic [DATA_BITS-1:0]        data_q,     data_d;
    logic                        valid_q,    valid_d;
    logic                        clr_q,      clr_d;
    logic                        perr_q,     perr_d;
    logic                        ferr_q,     ferr_d;
    logic                        ovr_q,      ovr_d;

    // A good stop bit was sampled this cycle.
    logic frame_done;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rx_prev_d  = rx_sync;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_acc_d  = par_acc_q;
        par_bit_d  = par_bit_q;
        data_d     = data_q;
        valid_d    = valid_q;
        clr_d      = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        frame_done = 1'b0;

        // The consumer takes the word. If a new word loads in this same
        // cycle, the load code below sets valid_d again.
        if (valid_q && Rx_Ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            UART_RX_IDLE: begin
                // Synchronized 1->0 edge. The strobe is ignored here, so the
                // baud counter is re-aligned before any bit is sampled.
                if (rx_prev_q && !rx_sync) begin
                    clr_d   = 1'b1;
                    state_d = UART_RX_START;
                end
            end

            UART_RX_START: begin
                if (Baud_rate_re_i) begin
                    if (rx_sync) begin
                        // Glitch shorter than half a bit: drop it and output nothing.
                        state_d = UART_RX_IDLE;
                    end else begin
                        state_d   = UART_RX_DATA;
                        bit_cnt_d = '0;
                        par_acc_d = 1'b0;
                    end
                end
            end

            UART_RX_DATA: begin
                if (Baud_rate_re_i) begin
                    // Bits arrive LSB first. Shifting each one into the MSB
                    // leaves the word right-aligned after DATA_BITS samples.
                    shreg_d   = {rx_sync, shreg_q[DATA_BITS-1:1]};
                    par_acc_d = par_acc_q ^ rx_sync;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = Parity_En_i ? UART_RX_PARITY : UART_RX_STOP;
                    end
                end
            end

            UART_RX_PARITY: begin
                if (Baud_rate_re_i) begin
                    par_bit_d = rx_sync;
                    state_d   = UART_RX_STOP;
                end
            end

            UART_RX_STOP: begin
                if (Baud_rate_re_i) begin
                    if (rx_sync) begin
                        frame_done = 1'b1;
                        state_d    = UART_RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = UART_RX_BREAK;
                    end
                end
            end

            UART_RX_BREAK: begin
                // Wait for the line to go high again. Edge detect restarts
                // from a high line, so a held-low line never starts a frame.
                if (rx_sync) begin
                    state_d = UART_RX_IDLE;
                end
            end

            default: begin
                state_d = UART_RX_IDLE;
            end
        endcase

        // Frame completion. The register can load if it is empty or is
        // being read in this cycle. Otherwise the new word is dropped.
        if (frame_done) begin
            if (!valid_q || Rx_Ready_i) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
                perr_d  = Parity_En_i && uart_parity_bad(par_acc_q, par_bit_q, Parity_Odd_i);
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Bus_Clk_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            state_q   <= UART_RX_IDLE;
            rx_prev_q <= UART_IDLE_LEVEL;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_acc_q <= 1'b0;
            par_bit_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            clr_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_prev_q <= rx_prev_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_acc_q <= par_acc_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            clr_q     <= clr_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Clear_Br_Cnt_o = clr_q;
    assign Rx_Data_o      = data_q;
    assign Rx_Valid_o     = valid_q;
    assign Parity_Err_o   = perr_q;
    assign Frame_Err_o    = ferr_q;
    assign Overrun_Err_o  = ovr_q;
    assign Busy_o         = (state_q != UART_RX_IDLE);

endmodule : fcb_uart_rx

// File: tb/tb_fcb_uart_rx.sv
// Purpose: self-checking bench for fcb_uart_rx with a behavioural baud strobe source.
// Latency: n/a.
// Backpressure: n/a.
module tb_fcb_uart_rx;

    localparam int D    = 4;
    localparam int BITS = 8;
    localparam int SYNC = 2;

    logic            Bus_Clk_i      = 1'b0;
    logic            RSTn_i         = 1'b0;
    logic            Rx_i           = 1'b1;
    logic            Baud_rate_re_i = 1'b0;
    logic            Parity_En_i    = 1'b0;
    logic            Parity_Odd_i   = 1'b0;
    logic            Rx_Ready_i;
    logic            Clear_Br_Cnt_o;
    logic [BITS-1:0] Rx_Data_o;
    logic            Rx_Valid_o;
    logic            Parity_Err_o;
    logic            Frame_Err_o;
    logic            Overrun_Err_o;
    logic            Busy_o;

    // Ready is a plain level. It can also be raised only during the
    // stop-bit strobe, so a read lands in the frame-completion cycle.
    logic rdy_q       = 1'b0;
    logic rdy_on_stop = 1'b0;
    logic in_stop     = 1'b0;
    assign Rx_Ready_i = rdy_q | (rdy_on_stop & in_stop & Baud_rate_re_i);

    int checks = 0;
    int errors = 0;

    fcb_uart_rx #(
        .DATA_BITS   (BITS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .Bus_Clk_i      (Bus_Clk_i),
        .RSTn_i         (RSTn_i),
        .Rx_i           (Rx_i),
        .Baud_rate_re_i (Baud_rate_re_i),
        .Clear_Br_Cnt_o (Clear_Br_Cnt_o),
        .Parity_En_i    (Parity_En_i),
        .Parity_Odd_i   (Parity_Odd_i),
        .Rx_Data_o      (Rx_Data_o),
        .Rx_Valid_o     (Rx_Valid_o),
        .Rx_Ready_i     (Rx_Ready_i),
        .Parity_Err_o   (Parity_Err_o),
        .Frame_Err_o    (Frame_Err_o),
        .Overrun_Err_o  (Overrun_Err_o),
        .Busy_o         (Busy_o)
    );

    always #5 Bus_Clk_i = ~Bus_Clk_i;

    int cyc = 0;
    always @(posedge Bus_Clk_i) cyc <= cyc + 1;

    // Baud generator model. The clear pulse zeroes the counter. The first
    // strobe comes D cycles later, then one strobe every 2D cycles.
    int bcnt   = 1000;
    int re_cyc = 0;
    always @(negedge Bus_Clk_i) begin
        if (Clear_Br_Cnt_o) bcnt = 0;
        else                bcnt = bcnt + 1;
        Baud_rate_re_i = (bcnt >= D) && (((bcnt - D) % (2 * D)) == 0);
        if (Baud_rate_re_i) re_cyc = cyc;
    end

    // Output event monitor. It counts events and records timestamps.
    // The checks are made in the test tasks.
    int   n_clr = 0, n_vrise = 0, n_vfall = 0, n_pe = 0, n_pe_v = 0, n_fe = 0, n_ov = 0;
    int   clr_cyc = 0, vrise_delta = 0;
    logic v_prev = 1'b0;
    always @(negedge Bus_Clk_i) begin
        if (Clear_Br_Cnt_o) begin n_clr = n_clr + 1; clr_cyc = cyc; end
        if (Rx_Valid_o && !v_prev) begin n_vrise = n_vrise + 1; vrise_delta = cyc - re_cyc; end
        if (!Rx_Valid_o && v_prev) n_vfall = n_vfall + 1;
        if (Parity_Err_o) begin n_pe = n_pe + 1; if (Rx_Valid_o) n_pe_v = n_pe_v + 1; end
        if (Frame_Err_o) n_fe = n_fe + 1;
        if (Overrun_Err_o) n_ov = n_ov + 1;
        v_prev = Rx_Valid_o;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_bit(input logic b);
        Rx_i = b;
        repeat (2 * D) @(negedge Bus_Clk_i);
    endtask

    task automatic send_frame(input logic [BITS-1:0] data, input logic pen,
                              input logic pbit, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < BITS; i++) drive_bit(data[i]);
        if (pen) drive_bit(pbit);
        in_stop = 1'b1;
        drive_bit(stop);
        in_stop = 1'b0;
    endtask

    task automatic idle(input int n);
        Rx_i = 1'b1;
        repeat (n) @(negedge Bus_Clk_i);
    endtask

    task automatic consume();
        rdy_q = 1'b1;
        @(negedge Bus_Clk_i);
        rdy_q = 1'b0;
    endtask

    // Reference for the parity error: count the ones in the data and the
    // parity bit. The error is expected when parity is enabled and the
    // oddness of that count does not match the configured mode.
    function automatic logic model_perr(input logic [BITS-1:0] data, input logic pbit,
                                        input logic pen, input logic odd);
        int ones;
        ones = $countones(data) + int'(pbit);
        return pen && ((ones % 2) != int'(odd));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge Bus_Clk_i);
        checks++;
        if ({Rx_Valid_o, Clear_Br_Cnt_o, Parity_Err_o, Frame_Err_o, Overrun_Err_o, Busy_o} !== 6'b0) begin
            errors++; $display("FAIL reset_flags_in_reset: got %b expected 000000",
                {Rx_Valid_o, Clear_Br_Cnt_o, Parity_Err_o, Frame_Err_o, Overrun_Err_o, Busy_o});
        end
        checks++;
        if (Rx_Data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", Rx_Data_o); end
        RSTn_i = 1'b1;
        repeat (4) @(negedge Bus_Clk_i);
        checks++;
        if ({Rx_Valid_o, Clear_Br_Cnt_o, Parity_Err_o, Frame_Err_o, Overrun_Err_o, Busy_o} !== 6'b0) begin
            errors++; $display("FAIL reset_flags_after_release: got %b expected 000000",
                {Rx_Valid_o, Clear_Br_Cnt_o, Parity_Err_o, Frame_Err_o, Overrun_Err_o, Busy_o});
        end
    endtask

    task automatic test_basic();
        int  bv, bp, bf, bo;
        bit  ok;
        Parity_En_i = 1'b0;
        bv = n_vrise; bp = n_pe; bf = n_fe; bo = n_ov;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(4);
        checks++;
        if (Rx_Valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", Rx_Valid_o); end
        checks++;
        if (Rx_Data_o !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", Rx_Data_o); end
        checks++;
        if (n_vrise - bv !== 1) begin errors++; $display("FAIL basic_vrise_count: got %0d expected 1", n_vrise - bv); end
        checks++;
        if (vrise_delta !== 1) begin errors++; $display("FAIL basic_valid_latency: got %0d expected 1", vrise_delta); end
        checks++;
        if ((n_pe - bp) + (n_fe - bf) + (n_ov - bo) !== 0) begin
            errors++; $display("FAIL basic_no_errors: got %0d expected 0", (n_pe - bp) + (n_fe - bf) + (n_ov - bo));
        end
        ok = 1'b1;
        repeat (20) begin
            @(negedge Bus_Clk_i);
            if (Rx_Valid_o !== 1'b1 || Rx_Data_o !== 8'hA5) ok = 1'b0;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_hold: got unstable expected stable a5"); end
        consume();
        checks++;
        if (Rx_Valid_o !== 1'b0) begin errors++; $display("FAIL basic_clear_after_ready: got %b expected 0", Rx_Valid_o); end
    endtask

    task automatic test_false_start();
        int bc, bv, fall;
        bc = n_clr; bv = n_vrise; fall = cyc;
        Rx_i = 1'b0;
        repeat (3) @(negedge Bus_Clk_i);
        Rx_i = 1'b1;
        repeat (2) @(negedge Bus_Clk_i);
        checks++;
        if (Busy_o !== 1'b1) begin errors++; $display("FAIL false_start_busy: got %b expected 1", Busy_o); end
        repeat (6 * D) @(negedge Bus_Clk_i);
        checks++;
        if (n_clr - bc !== 1) begin errors++; $display("FAIL false_start_clear_count: got %0d expected 1", n_clr - bc); end
        checks++;
        if (clr_cyc - fall !== SYNC + 1) begin
            errors++; $display("FAIL start_latency: got %0d expected %0d", clr_cyc - fall, SYNC + 1);
        end
        checks++;
        if (n_vrise - bv !== 0) begin errors++; $display("FAIL false_start_no_valid: got %0d expected 0", n_vrise - bv); end
        checks++;
        if (Busy_o !== 1'b0) begin errors++; $display("FAIL false_start_idle: got %b expected 0", Busy_o); end
    endtask

    task automatic test_parity();
        int   bp, bpv;
        logic pbit, exp;
        Parity_En_i  = 1'b1;
        Parity_Odd_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pbit = (k == 0);
            exp  = model_perr(8'h3C, pbit, 1'b1, 1'b0);
            bp = n_pe; bpv = n_pe_v;
            send_frame(8'h3C, 1'b1, pbit, 1'b1);
            idle(4);
            checks++;
            if (Rx_Valid_o !== 1'b1 || Rx_Data_o !== 8'h3C) begin
                errors++; $display("FAIL parity_data[%0d]: got %b/%h expected 1/3c", k, Rx_Valid_o, Rx_Data_o);
            end
            checks++;
            if (n_pe - bp !== int'(exp)) begin
                errors++; $display("FAIL parity_err_count[%0d]: got %0d expected %0d", k, n_pe - bp, exp);
            end
            checks++;
            if (n_pe_v - bpv !== int'(exp)) begin
                errors++; $display("FAIL parity_err_with_valid[%0d]: got %0d expected %0d", k, n_pe_v - bpv, exp);
            end
            consume();
        end
        Parity_En_i = 1'b0;
    endtask

    task automatic test_break();
        int bc, bv, bf;
        bit ok;
        bc = n_clr; bv = n_vrise; bf = n_fe;
        send_frame(8'h96, 1'b0, 1'b0, 1'b0);
        ok = 1'b1;
        repeat (40) begin
            @(negedge Bus_Clk_i);
            if (Busy_o !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL break_busy_held: got low expected high"); end
        idle(8 * D);
        checks++;
        if (n_fe - bf !== 1) begin errors++; $display("FAIL break_frame_err: got %0d expected 1", n_fe - bf); end
        checks++;
        if (n_vrise - bv !== 0) begin errors++; $display("FAIL break_no_valid: got %0d expected 0", n_vrise - bv); end
        checks++;
        if (n_clr - bc !== 1) begin errors++; $display("FAIL break_no_false_start: got %0d expected 1", n_clr - bc); end
        checks++;
        if (Busy_o !== 1'b0) begin errors++; $display("FAIL break_idle: got %b expected 0", Busy_o); end
    endtask

    task automatic test_back_to_back();
        int bo, bv, bf;
        bo = n_ov; bv = n_vrise;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        idle(4);
        checks++;
        if (Rx_Valid_o !== 1'b1 || Rx_Data_o !== 8'h11) begin
            errors++; $display("FAIL overrun_keep_old: got %b/%h expected 1/11", Rx_Valid_o, Rx_Data_o);
        end
        checks++;
        if (n_ov - bo !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d expected 1", n_ov - bo); end
        checks++;
        if (n_vrise - bv !== 1) begin errors++; $display("FAIL overrun_vrise: got %0d expected 1", n_vrise - bv); end
        bo = n_ov; bv = n_vrise; bf = n_vfall;
        rdy_on_stop = 1'b1;
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        rdy_on_stop = 1'b0;
        idle(4);
        checks++;
        if (Rx_Valid_o !== 1'b1 || Rx_Data_o !== 8'h22) begin
            errors++; $display("FAIL ready_same_cycle_load: got %b/%h expected 1/22", Rx_Valid_o, Rx_Data_o);
        end
        checks++;
        if (n_ov - bo !== 0) begin errors++; $display("FAIL ready_same_cycle_no_overrun: got %0d expected 0", n_ov - bo); end
        checks++;
        if (n_vfall - bf !== 0) begin errors++; $display("FAIL ready_same_cycle_valid_stays: got %0d falls expected 0", n_vfall - bf); end
    endtask

    task automatic test_reset_mid_frame();
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        checks++;
        if (Busy_o !== 1'b1) begin errors++; $display("FAIL mid_reset_precondition_busy: got %b expected 1", Busy_o); end
        #2;
        RSTn_i = 1'b0;
        #1;
        checks++;
        if ({Rx_Valid_o, Clear_Br_Cnt_o, Parity_Err_o, Frame_Err_o, Overrun_Err_o, Busy_o} !== 6'b0 || Rx_Data_o !== 8'h00) begin
            errors++; $display("FAIL mid_reset_async: got %b/%h expected 000000/00",
                {Rx_Valid_o, Clear_Br_Cnt_o, Parity_Err_o, Frame_Err_o, Overrun_Err_o, Busy_o}, Rx_Data_o);
        end
        @(negedge Bus_Clk_i);
        Rx_i = 1'b1;
        repeat (3) @(negedge Bus_Clk_i);
        RSTn_i = 1'b1;
        repeat (3) @(negedge Bus_Clk_i);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        idle(4);
        checks++;
        if (Rx_Valid_o !== 1'b1 || Rx_Data_o !== 8'h5A) begin
            errors++; $display("FAIL mid_reset_recover: got %b/%h expected 1/5a", Rx_Valid_o, Rx_Data_o);
        end
        consume();
    endtask

    task automatic test_random();
        logic [BITS-1:0] data;
        logic            pen, odd, bad, pbit, exp;
        int              bp, bf, bo;
        for (int n = 0; n < 24; n++) begin
            data = BITS'($urandom);
            pen  = 1'($urandom_range(0, 1));
            odd  = 1'($urandom_range(0, 1));
            bad  = ($urandom_range(0, 3) == 0);
            // Choose the parity bit so that the total count of ones is correct
            // for the mode, then invert it when this frame must fail.
            pbit = ((($countones(data) % 2) == 1) != odd) ^ bad;
            exp  = model_perr(data, pbit, pen, odd);
            Parity_En_i  = pen;
            Parity_Odd_i = odd;
            bp = n_pe; bf = n_fe; bo = n_ov;
            send_frame(data, pen, pbit, 1'b1);
            idle(3);
            checks++;
            if (Rx_Valid_o !== 1'b1 || Rx_Data_o !== data) begin
                errors++; $display("FAIL random_data[%0d]: got %b/%h expected 1/%h", n, Rx_Valid_o, Rx_Data_o, data);
            end
            checks++;
            if (n_pe - bp !== int'(exp)) begin
                errors++; $display("FAIL random_parity[%0d]: got %0d expected %0d", n, n_pe - bp, exp);
            end
            checks++;
            if ((n_fe - bf) + (n_ov - bo) !== 0) begin
                errors++; $display("FAIL random_no_frame_ovr[%0d]: got %0d expected 0", n, (n_fe - bf) + (n_ov - bo));
            end
            consume();
            idle($urandom_range(0, 6));
        end
        Parity_En_i = 1'b0;
        Parity_Odd_i = 1'b0;
    endtask

    initial begin
        test_reset();
        idle(10);
        test_basic();
        idle(5);
        test_false_start();
        idle(5);
        test_parity();
        idle(5);
        test_break();
        idle(5);
        test_back_to_back();
        idle(5);
        test_reset_mid_frame();
        idle(5);
        test_random();
        idle(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fcb_uart_rx
